// File: rtl/dlsc_pcie_s6_inbound_cpl_pkg.sv
// Shared definitions for the inbound completion builder: TLP fmt/type codes,
// completion status codes, AXI response encodings, FSM state type and the
// request-info record carried from the dispatcher to the completion builder.
package dlsc_pcie_s6_inbound_cpl_pkg;

  // TLP fmt/type for completions (with and without payload)
  localparam logic [1:0] FMT_CPLD = 2'b10;
  localparam logic [1:0] FMT_CPL  = 2'b00;
  localparam logic [4:0] TYPE_CPL = 5'b01010;

  // Completion status field
  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  // AXI response encodings
  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_H0,
    ST_H1,
    ST_H2,
    ST_DATA,
    ST_DROP
  } state_t;

  typedef struct packed {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
  } info_t;

  // A zero-length OKAY fragment is a protocol violation upstream, so it is
  // reported as a completer abort rather than a successful completion.
  function automatic logic [2:0] cpl_status(input logic [1:0] resp, input logic [9:0] len);
    logic [2:0] st;
    st = CPL_UR;
    case (resp)
      AXI_OKAY:   st = (len == 10'd0) ? CPL_CA : CPL_SC;
      AXI_SLVERR: st = CPL_CA;
      AXI_EXOKAY: st = CPL_UR;
      AXI_DECERR: st = CPL_UR;
      default:    st = CPL_UR;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dlsc_rvh_fifo.sv
// Generic ready/valid FIFO with first-word-fall-through read port.
// Ports: clk/rst (sync, active-high); in_* write side (in_ready_o = not full);
// out_* read side (out_valid_o = not empty, out_data_o = head entry).
module dlsc_rvh_fifo #(
  parameter int DATA  = 8,
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [DATA-1:0] in_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [DATA-1:0] out_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            push;
  logic            pop;

  assign in_ready_o  = (cnt_q != CNT_FULL);
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

endmodule

// File: rtl/dlsc_pcie_s6_inbound_cpl.sv
// Builds PCIe completion TLPs (CplD on success, Cpl with UR/CA on error) from
// read-stage fragments and per-request info, streaming them to the S6 TRN adapter.
// Ports: clk/rst (sync, active-high); completer_id; info_* request-info push;
// cpl_h_* fragment header; cpl_d_* fragment payload; tx_* TLP stream out.
// Optional macro DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN adds the cpl_err_count port.
module dlsc_pcie_s6_inbound_cpl
  import dlsc_pcie_s6_inbound_cpl_pkg::*;
#(
  parameter int INFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] completer_id,
  output logic        info_ready,
  input  logic        info_valid,
  input  logic [15:0] info_req_id,
  input  logic [7:0]  info_tag,
  input  logic [2:0]  info_tc,
  input  logic [1:0]  info_attr,
  output logic        cpl_h_ready,
  input  logic        cpl_h_valid,
  input  logic [6:0]  cpl_h_addr,
  input  logic [9:0]  cpl_h_len,
  input  logic [11:0] cpl_h_bytes,
  input  logic        cpl_h_last,
  input  logic [1:0]  cpl_h_resp,
  output logic        cpl_d_ready,
  input  logic        cpl_d_valid,
  input  logic [31:0] cpl_d_data,
  input  logic        cpl_d_last,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [31:0] tx_data,
  output logic        tx_sof,
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
  output logic [15:0] cpl_err_count,
`endif
  output logic        tx_eof
);

  // Request-info FIFO; the head entry stays put until the last fragment of
  // its request is done, so header DWs read it directly.
  info_t                   info_in;
  info_t                   info_out;
  logic [$bits(info_t)-1:0] info_out_vec;
  logic                    info_vld;
  logic                    info_pop;

  assign info_in  = '{req_id: info_req_id, tag: info_tag, tc: info_tc, attr: info_attr};
  assign info_out = info_t'(info_out_vec);

  dlsc_rvh_fifo #(
    .DATA  ($bits(info_t)),
    .DEPTH (INFO_DEPTH)
  ) u_info_fifo (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (info_valid),
    .in_ready_o  (info_ready),
    .in_data_i   (info_in),
    .out_valid_o (info_vld),
    .out_ready_i (info_pop),
    .out_data_o  (info_out_vec)
  );

  state_t      state_q;
  logic        abort_q;
  logic        err_q;
  logic [2:0]  status_q;
  logic [6:0]  addr_q;
  logic [9:0]  len_q;
  logic [11:0] bytes_q;
  logic        last_q;
  logic        hrdy_q;
  logic        frag_done;

  // hrdy_q is the one-cycle completion pulse; during it the header input is
  // still the old fragment, so IDLE must not re-latch it.
  assign cpl_h_ready = hrdy_q;
  assign info_pop    = hrdy_q && last_q;

  // Payload-less fragments (len 0) have nothing to drain.
  always_comb begin
    frag_done = 1'b0;
    case (state_q)
      ST_H2:   frag_done = tx_ready && err_q && (len_q == 10'd0);
      ST_DATA: frag_done = cpl_d_valid && tx_ready && cpl_d_last;
      ST_DROP: frag_done = (len_q == 10'd0) || (cpl_d_valid && cpl_d_last);
      default: frag_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      status_q <= CPL_SC;
      addr_q   <= '0;
      len_q    <= '0;
      bytes_q  <= '0;
      last_q   <= 1'b0;
      hrdy_q   <= 1'b0;
    end else begin
      hrdy_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpl_h_valid && info_vld && !hrdy_q) begin
            addr_q   <= cpl_h_addr;
            len_q    <= cpl_h_len;
            bytes_q  <= cpl_h_bytes;
            last_q   <= cpl_h_last;
            err_q    <= (cpl_h_resp != AXI_OKAY) || (cpl_h_len == 10'd0);
            status_q <= cpl_status(cpl_h_resp, cpl_h_len);
            // Fragments following an error in the same request are discarded.
            state_q  <= abort_q ? ST_DROP : ST_H0;
          end
        end
        ST_H0:   if (tx_ready) state_q <= ST_H1;
        ST_H1:   if (tx_ready) state_q <= ST_H2;
        ST_H2:   if (tx_ready) state_q <= err_q ? ST_DROP : ST_DATA;
        default: ;
      endcase
      if (frag_done) begin
        state_q <= ST_IDLE;
        hrdy_q  <= 1'b1;
        abort_q <= (abort_q || err_q) && !last_q;
      end
    end
  end

  // Header DWs; error completions carry no payload and no lower address.
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic [31:0] dw2;

  assign dw0 = {1'b0, (err_q ? FMT_CPL : FMT_CPLD), TYPE_CPL, 1'b0, info_out.tc, 4'b0000,
                2'b00, info_out.attr, 2'b00, (err_q ? 10'd0 : len_q)};
  assign dw1 = {completer_id, status_q, 1'b0, bytes_q};
  assign dw2 = {info_out.req_id, info_out.tag, 1'b0, (err_q ? 7'd0 : addr_q)};

  // TX is decoded from the registered state so the payload can cut straight
  // through from cpl_d with no bubbles; stability under stall in DATA follows
  // from cpl_d holding while cpl_d_ready (= tx_ready) is low.
  always_comb begin
    tx_valid    = 1'b0;
    tx_data     = '0;
    tx_sof      = 1'b0;
    tx_eof      = 1'b0;
    cpl_d_ready = 1'b0;
    case (state_q)
      ST_H0: begin
        tx_valid = 1'b1;
        tx_sof   = 1'b1;
        tx_data  = dw0;
      end
      ST_H1: begin
        tx_valid = 1'b1;
        tx_data  = dw1;
      end
      ST_H2: begin
        tx_valid = 1'b1;
        tx_data  = dw2;
        tx_eof   = err_q;
      end
      ST_DATA: begin
        tx_valid    = cpl_d_valid;
        tx_data     = cpl_d_data;
        tx_eof      = cpl_d_last;
        cpl_d_ready = tx_ready;
      end
      ST_DROP: cpl_d_ready = (len_q != 10'd0);
      default: ;
    endcase
  end

`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
  logic [15:0] err_cnt_q;

  assign cpl_err_count = err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (state_q == ST_H2 && tx_ready && err_q && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_cpl.sv
// Self-checking bench for dlsc_pcie_s6_inbound_cpl: table of single-fragment
// completions, split-request abort, empty/full info FIFO, backpressure, mid-TLP reset.
module tb_dlsc_pcie_s6_inbound_cpl;

  localparam logic [15:0] CID = 16'h0A10;
  localparam int TMO = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic        info_ready, info_valid;
  logic [15:0] info_req_id;
  logic [7:0]  info_tag;
  logic [2:0]  info_tc;
  logic [1:0]  info_attr;
  logic        cpl_h_ready, cpl_h_valid, cpl_h_last;
  logic [6:0]  cpl_h_addr;
  logic [9:0]  cpl_h_len;
  logic [11:0] cpl_h_bytes;
  logic [1:0]  cpl_h_resp;
  logic        cpl_d_ready, cpl_d_valid, cpl_d_last;
  logic [31:0] cpl_d_data;
  logic        tx_ready, tx_valid, tx_sof, tx_eof;
  logic [31:0] tx_data;
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
  logic [15:0] cpl_err_count;
`endif

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_cpl #(.INFO_DEPTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .completer_id (CID),
    .info_ready   (info_ready),
    .info_valid   (info_valid),
    .info_req_id  (info_req_id),
    .info_tag     (info_tag),
    .info_tc      (info_tc),
    .info_attr    (info_attr),
    .cpl_h_ready  (cpl_h_ready),
    .cpl_h_valid  (cpl_h_valid),
    .cpl_h_addr   (cpl_h_addr),
    .cpl_h_len    (cpl_h_len),
    .cpl_h_bytes  (cpl_h_bytes),
    .cpl_h_last   (cpl_h_last),
    .cpl_h_resp   (cpl_h_resp),
    .cpl_d_ready  (cpl_d_ready),
    .cpl_d_valid  (cpl_d_valid),
    .cpl_d_data   (cpl_d_data),
    .cpl_d_last   (cpl_d_last),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_sof       (tx_sof),
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
    .cpl_err_count(cpl_err_count),
`endif
    .tx_eof       (tx_eof)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eof;
  } beat_t;

  typedef struct {
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [2:0]  tc;
    logic [1:0]  attr;
    logic [6:0]  addr;
    logic [9:0]  len;
    logic [11:0] bytes;
    logic [1:0]  resp;
    logic [31:0] dw0, dw1, dw2;
    logic        err;
  } vec_t;

  int    checks = 0;
  int    errors = 0;
  logic  bp_en  = 1'b0;
  beat_t got_q[$];
  beat_t exp_q[$];

  // Monitor: record accepted beats and require stalled beats to hold.
  initial begin
    logic  stall;
    beat_t stall_b, cur;
    stall = 1'b0;
    stall_b = '0;
    forever begin
      @(negedge clk);
      cur = '{data: tx_data, sof: tx_sof, eof: tx_eof};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          checks++;
          if (tx_valid !== 1'b1 || cur !== stall_b) begin
            errors++;
            $display("FAIL stall_stable got valid=%b beat=%h want valid=1 beat=%h", tx_valid, cur, stall_b);
          end
        end
        if (tx_valid && tx_ready) got_q.push_back(cur);
        stall   = tx_valid && !tx_ready;
        stall_b = cur;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) tx_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  task automatic check_q(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s beat count got %0d want %0d", name, got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s beat %0d got %h want %h", name, i, got_q[i], exp_q[i]);
        end
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic exp_beat(input logic [31:0] d, input logic s, input logic e);
    beat_t b;
    b.data = d;
    b.sof  = s;
    b.eof  = e;
    exp_q.push_back(b);
  endtask

  task automatic exp_tlp(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic err, input logic [31:0] base, input int len);
    exp_beat(d0, 1'b1, 1'b0);
    exp_beat(d1, 1'b0, 1'b0);
    exp_beat(d2, 1'b0, err);
    if (!err) for (int k = 0; k < len; k++) exp_beat(base + 32'(k), 1'b0, k == len - 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_info(input logic [15:0] rid, input logic [7:0] tag,
                           input logic [2:0] tc, input logic [1:0] attr);
    int n;
    info_req_id = rid;
    info_tag    = tag;
    info_tc     = tc;
    info_attr   = attr;
    info_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!info_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!info_ready) timeout_fail("info_push");
    @(posedge clk);
    #1 info_valid = 1'b0;
  endtask

  task automatic send_frag(input logic [6:0] addr, input logic [9:0] len, input logic [11:0] bytes,
                           input logic last, input logic [1:0] resp, input logic [31:0] base);
    fork
      begin
        int n;
        cpl_h_addr  = addr;
        cpl_h_len   = len;
        cpl_h_bytes = bytes;
        cpl_h_last  = last;
        cpl_h_resp  = resp;
        cpl_h_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cpl_h_ready && n < TMO) begin
          @(negedge clk);
          n++;
        end
        if (!cpl_h_ready) timeout_fail("cpl_h_ready");
        @(posedge clk);
        #1 cpl_h_valid = 1'b0;
      end
      begin
        int n;
        for (int k = 0; k < int'(len); k++) begin
          cpl_d_valid = 1'b1;
          cpl_d_data  = base + 32'(k);
          cpl_d_last  = (k == int'(len) - 1);
          n = 0;
          @(negedge clk);
          while (!cpl_d_ready && n < TMO) begin
            @(negedge clk);
            n++;
          end
          if (!cpl_d_ready) begin
            timeout_fail("cpl_d_ready");
            break;
          end
          @(posedge clk);
          #1;
        end
        cpl_d_valid = 1'b0;
        cpl_d_last  = 1'b0;
      end
    join
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    logic quiet;
    vecs[0] = '{16'h0100, 8'h05, 3'd0, 2'd0, 7'h04, 10'd2,  12'h008, 2'b00, 32'h4A000002, 32'h0A100008, 32'h01000504, 1'b0};
    vecs[1] = '{16'h0100, 8'h05, 3'd0, 2'd0, 7'h04, 10'd2,  12'h008, 2'b10, 32'h0A000000, 32'h0A108008, 32'h01000500, 1'b1};
    vecs[2] = '{16'h1234, 8'hA7, 3'd3, 2'd2, 7'h7F, 10'd1,  12'h004, 2'b00, 32'h4A302001, 32'h0A100004, 32'h1234A77F, 1'b0};
    vecs[3] = '{16'hFFFF, 8'hFF, 3'd7, 2'd3, 7'h10, 10'd3,  12'hFFF, 2'b11, 32'h0A703000, 32'h0A102FFF, 32'hFFFFFF00, 1'b1};
    vecs[4] = '{16'h0002, 8'h10, 3'd0, 2'd1, 7'h08, 10'd1,  12'h004, 2'b01, 32'h0A001000, 32'h0A102004, 32'h00021000, 1'b1};
    vecs[5] = '{16'h0003, 8'h20, 3'd0, 2'd0, 7'h0C, 10'd0,  12'h000, 2'b00, 32'h0A000000, 32'h0A108000, 32'h00032000, 1'b1};
    vecs[6] = '{16'h4321, 8'h3C, 3'd1, 2'd0, 7'h40, 10'd16, 12'h040, 2'b00, 32'h4A100010, 32'h0A100040, 32'h43213C40, 1'b0};

    rst = 1'b1;
    info_valid = 1'b0; info_req_id = '0; info_tag = '0; info_tc = '0; info_attr = '0;
    cpl_h_valid = 1'b0; cpl_h_addr = '0; cpl_h_len = '0; cpl_h_bytes = '0; cpl_h_last = 1'b0; cpl_h_resp = '0;
    cpl_d_valid = 1'b0; cpl_d_data = '0; cpl_d_last = 1'b0;
    tx_ready = 1'b1;
    do_reset();

    @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_sof", 32'(tx_sof), 32'd0);
    chk("rst_tx_eof", 32'(tx_eof), 32'd0);
    chk("rst_cpl_h_ready", 32'(cpl_h_ready), 32'd0);
    chk("rst_cpl_d_ready", 32'(cpl_d_ready), 32'd0);
    chk("rst_info_ready", 32'(info_ready), 32'd1);
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
    chk("rst_err_count", 32'(cpl_err_count), 32'd0);
`endif
    @(posedge clk);
    #1;

    // Single-fragment completions
    for (int i = 0; i < 7; i++) begin
      logic [31:0] base;
      base = 32'hD0000000 | (32'(i) << 12);
      send_info(vecs[i].req_id, vecs[i].tag, vecs[i].tc, vecs[i].attr);
      exp_tlp(vecs[i].dw0, vecs[i].dw1, vecs[i].dw2, vecs[i].err, base, int'(vecs[i].len));
      send_frag(vecs[i].addr, vecs[i].len, vecs[i].bytes, 1'b1, vecs[i].resp, base);
      check_q($sformatf("vec%0d", i));
    end
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
    chk("err_count_table", 32'(cpl_err_count), 32'd4);
`endif

    // Split request: OKAY, DECERR, then a silently dropped tail; then the next request.
    send_info(16'h0A0A, 8'h11, 3'd0, 2'd0);
    send_info(16'h0B0B, 8'h22, 3'd0, 2'd0);
    exp_tlp(32'h4A000002, 32'h0A100018, 32'h0A0A1100, 1'b0, 32'hA1000000, 2);
    send_frag(7'h00, 10'd2, 12'h018, 1'b0, 2'b00, 32'hA1000000);
    check_q("split_frag1");
    exp_tlp(32'h0A000000, 32'h0A102010, 32'h0A0A1100, 1'b1, 32'hA2000000, 2);
    send_frag(7'h08, 10'd2, 12'h010, 1'b0, 2'b11, 32'hA2000000);
    check_q("split_frag2");
    send_frag(7'h10, 10'd2, 12'h008, 1'b1, 2'b00, 32'hA3000000);
    check_q("split_frag3");
    exp_tlp(32'h4A000001, 32'h0A100004, 32'h0B0B2204, 1'b0, 32'hB0000000, 1);
    send_frag(7'h04, 10'd1, 12'h004, 1'b1, 2'b00, 32'hB0000000);
    check_q("split_next_req");
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
    chk("err_count_split", 32'(cpl_err_count), 32'd5);
`endif

    // 50% tx backpressure over 64 OKAY completions
    bp_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [15:0] rid;
      logic [2:0]  tc;
      logic [1:0]  attr;
      logic [6:0]  addr;
      logic [9:0]  len;
      logic [31:0] base;
      rid  = 16'($urandom);
      tc   = 3'($urandom_range(0, 7));
      attr = 2'($urandom_range(0, 3));
      addr = 7'($urandom_range(0, 127));
      len  = 10'($urandom_range(1, 4));
      base = 32'hC0000000 | (32'(i) << 8);
      send_info(rid, 8'(i), tc, attr);
      exp_tlp({1'b0, 2'b10, 5'b01010, 1'b0, tc, 4'b0, 2'b0, attr, 2'b0, len},
              {CID, 3'b000, 1'b0, 12'(len) << 2},
              {rid, 8'(i), 1'b0, addr}, 1'b0, base, int'(len));
      send_frag(addr, len, 12'(len) << 2, 1'b1, 2'b00, base);
      check_q($sformatf("bp%0d", i));
    end
    bp_en = 1'b0;
    @(posedge clk);
    #1 tx_ready = 1'b1;

    // Header waiting on an empty info FIFO must not produce anything.
    cpl_h_addr = 7'h20; cpl_h_len = 10'd1; cpl_h_bytes = 12'h004; cpl_h_last = 1'b1; cpl_h_resp = 2'b00;
    cpl_h_valid = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid || cpl_h_ready) quiet = 1'b0;
    end
    chk("empty_info_quiet", 32'(quiet), 32'd1);
    @(posedge clk);
    #1;
    send_info(16'h7777, 8'h44, 3'd0, 2'd0);
    exp_tlp(32'h4A000001, 32'h0A100004, 32'h77774420, 1'b0, 32'hE0000000, 1);
    send_frag(7'h20, 10'd1, 12'h004, 1'b1, 2'b00, 32'hE0000000);
    check_q("late_info");

    for (int i = 0; i < 16; i++) send_info(16'h2000 + 16'(i), 8'(i), 3'd0, 2'd0);
    @(negedge clk);
    chk("info_full", 32'(info_ready), 32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of the payload
    do_reset();
    send_info(16'h5555, 8'h66, 3'd0, 2'd0);
    cpl_h_addr = 7'h00; cpl_h_len = 10'd2; cpl_h_bytes = 12'h008; cpl_h_last = 1'b1; cpl_h_resp = 2'b00;
    cpl_h_valid = 1'b1;
    cpl_d_valid = 1'b1; cpl_d_data = 32'hDEAD0001; cpl_d_last = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(tx_valid && tx_ready && tx_data == 32'hDEAD0001) && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) timeout_fail("rst_reach_data");
    @(posedge clk);
    #1 cpl_d_data = 32'hDEAD0002; cpl_d_last = 1'b1; tx_ready = 1'b0;
    @(negedge clk);
    chk("rst_pre_valid", 32'(tx_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_valid", 32'(tx_valid), 32'd0);
    chk("rst_mid_eof", 32'(tx_eof), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0; cpl_h_valid = 1'b0; cpl_d_valid = 1'b0; cpl_d_last = 1'b0; tx_ready = 1'b1;
    exp_beat(32'h4A000002, 1'b1, 1'b0);
    exp_beat(32'h0A100008, 1'b0, 1'b0);
    exp_beat(32'h55556600, 1'b0, 1'b0);
    exp_beat(32'hDEAD0001, 1'b0, 1'b0);
    check_q("rst_abandon");
`ifdef DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN
    chk("rst_err_count2", 32'(cpl_err_count), 32'd0);
`endif
    send_info(16'h6666, 8'h77, 3'd2, 2'd1);
    exp_tlp(32'h4A201002, 32'h0A100008, 32'h66667708, 1'b0, 32'hF0000000, 2);
    send_frag(7'h08, 10'd2, 12'h008, 1'b1, 2'b00, 32'hF0000000);
    check_q("post_rst");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dlsc_pcie_s6_inbound_cpl.md
DLSC_PCIE_S6_INBOUND_CPL -- requirements
Module: dlsc_pcie_s6_inbound_cpl

Interface
REQ-001 SHALL have parameter INFO_DEPTH, default 16: depth of the internal request-info FIFO.
REQ-002 SHALL have clk, input, 1: clock.
REQ-003 SHALL have rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have completer_id, input, 16: bus/dev/func, used in DW1[31:16].
REQ-005 SHALL have info_ready/info_valid (out/in, 1 each) and info_req_id (in, 16), info_tag (in, 8), info_tc (in, 3), info_attr (in, 2): one entry per accepted non-posted read, from the dispatcher.
REQ-006 SHALL have cpl_h_ready (out, 1), cpl_h_valid (in, 1), cpl_h_addr (in, 7), cpl_h_len (in, 10), cpl_h_bytes (in, 12), cpl_h_last (in, 1), cpl_h_resp (in, 2): completion header from the inbound read stage.
REQ-007 SHALL have cpl_d_ready (out, 1), cpl_d_valid (in, 1), cpl_d_data (in, 32), cpl_d_last (in, 1): completion payload; cpl_d_last marks the final DW of one fragment.
REQ-008 SHALL have tx_ready (in, 1), tx_valid (out, 1), tx_data (out, 32), tx_sof (out, 1), tx_eof (out, 1): active-high TLP stream to the S6 TRN adapter.
REQ-009 SHALL have cpl_err_count (out, 16), present only under the configuration macro.

Function
REQ-010 SHALL buffer info entries in an INFO_DEPTH FIFO; info_ready = FIFO not full.
REQ-011 SHALL use FSM states IDLE, H0, H1, H2, DATA, DROP.
REQ-012 IDLE->H0 SHALL occur when cpl_h_valid and the info FIFO is non-empty; header fields latch on this transition.
REQ-013 H0/H1/H2 SHALL each present one header DW, with tx_sof=1 in H0, and SHALL advance only on tx_valid && tx_ready.
REQ-014 DW0: fmt=2'b10, type=5'b01010 (CplD) on OKAY; fmt=2'b00 (Cpl) otherwise; TC=[22:20], attr=[13:12], length=[9:0] (length 0 for Cpl).
REQ-015 DW1: {completer_id, status[2:0], BCM=0, cpl_h_bytes}; status 000 for OKAY, 100 (CA) for SLVERR, 001 (UR) for DECERR or 2'b01.
REQ-016 DW2: {req_id, tag, 1'b0, lower_addr[6:0]}; lower_addr = cpl_h_addr on success, 0 on error.
REQ-017 On success, H2->DATA; DATA SHALL forward cpl_d to tx with cpl_d_ready = tx_ready, with tx_eof asserted on the beat where cpl_d_last=1, then go to IDLE.
REQ-018 On error, H2 SHALL assert tx_eof; the FSM SHALL then enter DROP and consume cpl_d (cpl_d_ready=1, nothing sent on tx) through cpl_d_last.
REQ-019 After an error, further fragments of the same request (up to and including cpl_h_last) SHALL be consumed (header and data dropped, no TLP sent); a sticky abort flag SHALL clear at cpl_h_last.
REQ-020 cpl_h_ready SHALL pulse for one cycle when the fragment is fully done; the info FIFO SHALL pop on the same cycle if cpl_h_last=1.
REQ-021 tx_valid SHALL be 0 in IDLE and DROP; the data path SHALL have zero bubble cycles between DWs when tx_ready stays high.
REQ-022 A fragment header with cpl_h_len=0 and OKAY status SHALL be treated as a protocol error: send CA and drop.
REQ-023 Once tx_valid is asserted, tx_data/sof/eof SHALL stay stable until tx_ready.

Reset
REQ-024 On rst: FSM=IDLE, info FIFO empty, abort flag=0, tx_valid=0, tx_sof=0, tx_eof=0, cpl_h_ready=0, cpl_d_ready=0, cpl_err_count=0.
REQ-025 A reset mid-TLP SHALL abandon the TLP immediately, with no eof sent.

Configuration
REQ-026 Macro DLSC_PCIE_S6_INBOUND_CPL_ERRCNT_EN: when defined, cpl_err_count increments (saturating at 0xFFFF) once per error Cpl sent; when undefined, the port and counter are absent and behaviour is otherwise identical.

Structure
REQ-027 The shared package SHALL hold: CplD/Cpl fmt/type constants, the completion status codes (SC/UR/CA), and the AXI resp encodings.
REQ-028 The info FIFO SHALL be the existing dlsc_rvh_fifo; there is no other sub-module.

Verification
REQ-029 Info (req_id 0x0100, tag 0x05), header len=2, bytes=8, addr=0x04, OKAY, last, data A,B -> tx: 0x4A000002, {cid,0x0008}, 0x01000504, A, B (eof on B); one info pop.
REQ-030 Same request with resp=SLVERR, len=2 -> 3-DW Cpl with status=100 and eof on DW2; both data DWs drained; nothing more on tx.
REQ-031 A request split into 3 fragments, the 2nd DECERR -> fragment 1 is CplD, fragment 2 is Cpl UR, fragment 3 is dropped silently; info popped once, at fragment 3.
REQ-032 Random tx_ready backpressure (50%) over 64 OKAY completions -> data matches in order, outputs stable under stall, no lost or duplicated DWs.
REQ-033 cpl_h_valid with an empty info FIFO -> no tx activity until info arrives; 16 infos queued -> info_ready=0.
REQ-034 rst asserted during DATA -> tx_valid=0 next cycle; the following completion is emitted correctly.
